voice_alloc: RTL and testbench
==============================

Name: voice_alloc

Overview:
- Downstream consumer of the PS/2 keyboard stage.
- Takes the 12-bit held-piano-key bitmask and the 2-bit octave select, then allocates held notes onto NV polyphonic wavetable voices.
- Outputs per voice: a gate, the note index, and a phase-increment tuning word for the wavetable oscillators.
- Crosses the filtered-PS/2-clock domain into the system clock domain. Performs oldest-voice stealing when all voices are busy.

Parameters:
- NV, 4, number of voices (2..8)
- INC_W, 24, tuning-word width per voice
- AGE_W, 4, per-voice age counter width (saturating)

Ports:
- clk  in  1  system clock
- ar  in  1  reset; synchronous, active-high
- key_mask  in  12  held piano keys, bit k = note k (C=0..B=11), asynchronous to clk
- octave  in  2  octave shift, synchronous to clk
- voice_gate  out  NV  1 = voice sounding
- voice_note  out  4*NV  note index of voice v at [4v+3:4v]
- voice_inc  out  INC_W*NV  tuning word of voice v at [INC_W*v+INC_W-1:INC_W*v]
- steal_pulse  out  1  one-cycle pulse when an active voice is stolen
- busy  out  1  1 while the scan FSM is not IDLE

Behaviour:
- Reset (ar=1 at a clk edge):
  - voice_gate=0, voice_note=0, all ages=0, voice_inc=TUNE[0], steal_pulse=0, busy=0.
  - prev_mask=0, sync regs=0, state=IDLE.
  - Reset mid-scan aborts the scan; pending changes are rediscovered afterwards against prev_mask=0.
- Sync:
  - key_mask passes through two flops (s1, s2), then a third register s3.
  - stable = (s2==s3). This rejects multi-bit skew.
- FSM IDLE:
  - If stable and s3!=prev_mask: latch snap=s3 and diff=s3^prev_mask, set idx=0, go to SCAN.
  - busy=1 from the next cycle.
- FSM SCAN:
  - One idx per cycle, 0..11. If diff[idx]=0, no action.
  - At idx=11: prev_mask<=snap, go to IDLE.
  - key_mask changes during SCAN are ignored until IDLE re-evaluates.
- NOTE_ON (snap[idx]=1):
  - If an active voice already holds idx: no change.
  - Else the target is the lowest-index voice with gate=0.
  - If no voice is free, the target is the active voice with the largest age (tie → lowest index), and steal_pulse=1 that cycle.
  - Target gets note<=idx, gate<=1, age<=0. Every other active voice gets age<=age+1, saturating at 2^AGE_W-1.
- NOTE_OFF (snap[idx]=0):
  - Every voice with gate=1 and note==idx gets gate<=0. Note and age are retained.
- Latency: if edge N is the first clk edge sampling a new key_mask, the action for key k is visible after edge N+4+k.
- Tuning:
  - voice_inc[v] is registered from TUNE[note[v]] << octave, one cycle after a note or octave change.
  - Octave changes retune held voices.
  - Width: INC_W. The shift cannot overflow with INC_W=24.
- Simultaneous on/off of different keys in one mask update: processed in ascending idx order.
- Idle voices: a voice with gate=0 and a stale note keeps its inc (release tail downstream).

Decomposition:
- Package voice_pkg holds:
  - NOTE_W=4, NKEYS=12
  - TUNE[0..11] constant array (50 MHz clk, 32-bit accumulator, octave 0 = C4 row): TUNE[0]=22474, TUNE[9]=37796, other entries equal-tempered.
  - FSM state enum {IDLE, SCAN}
- Sub-module mask_sync (2-flop + stability register, 12 bits wide) is natural and reusable.

Test Plan:
- Reset, then key_mask=0x001 → after edge N+4: voice_gate=0001, voice_note[0]=0; one edge later voice_inc[0]=22474.
- key_mask=0x201 at octave=0, then set octave=2 → voice_gate=0011, note1=9, inc1=37796; after the octave change inc0=89896 and inc1=151184.
- Press keys 0,1,2,3 sequentially (each scan completes), then add key 4 → steal_pulse high exactly one cycle, voice0 (oldest) gets note 4, voice_gate stays 1111.
- key_mask 0x003→0x001 → voice1 gate=0 after edge N+5, voice_note[1] still 1; voice0 unaffected.
- Toggle key_mask bits 0 and 5 with 1-cycle skew between them → no action until stable; a single scan applies both.
- Assert ar mid-SCAN with 0x00F pending → all outputs at reset values the next cycle; after release the scan restarts and allocates notes 0–3 to voices 0–3.

Source files
------------

// File: rtl/voice_pkg.sv
// Shared constants for the voice allocator.
//   NOTE_W / NKEYS : note index width and number of piano keys per octave row
//   TUNE           : phase increments for a 32-bit accumulator at 50 MHz,
//                    octave 0 = C4 row, equal-tempered around A4 = 440 Hz
//   state_e        : scan FSM states
package voice_pkg;
  localparam int NOTE_W = 4;
  localparam int NKEYS  = 12;
  localparam int TUNE_W = 16;

  localparam logic [TUNE_W-1:0] TUNE [NKEYS] = '{
    16'd22474, 16'd23810, 16'd25226, 16'd26726, 16'd28315, 16'd29998,
    16'd31782, 16'd33672, 16'd35674, 16'd37796, 16'd40043, 16'd42424
  };

  typedef enum logic {IDLE, SCAN} state_e;

  // Out-of-range indices map to C so a stale or corrupt note never reads
  // past the table.
  function automatic logic [TUNE_W-1:0] tune(input logic [NOTE_W-1:0] n);
    return (n < NOTE_W'(NKEYS)) ? TUNE[n] : TUNE[0];
  endfunction
endpackage

// File: rtl/mask_sync.sv
// Two-flop synchronizer plus a stability register for a multi-bit bus.
//   clk, ar : system clock, synchronous active-high reset
//   din     : asynchronous input bus
//   dout    : third-stage copy of the bus
//   stable  : 1 when stage two equals stage three, i.e. the bus held still
//             across one full clk period, so a skewed multi-bit change is
//             never consumed half-applied
module mask_sync
  import voice_pkg::*;
#(
  parameter int W = NKEYS
) (
  input  logic         clk,
  input  logic         ar,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         stable
);
  logic [W-1:0] s1_q, s2_q, s3_q;

  always_ff @(posedge clk) begin
    if (ar) begin
      s1_q <= '0;
      s2_q <= '0;
      s3_q <= '0;
    end else begin
      s1_q <= din;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign dout   = s3_q;
  assign stable = (s2_q == s3_q);
endmodule

// File: rtl/voice_alloc.sv
// Polyphonic voice allocator: maps held piano keys onto NV wavetable voices.
//   clk, ar     : system clock, synchronous active-high reset
//   key_mask    : held keys (bit k = note k), asynchronous to clk
//   octave      : octave shift applied to every voice's tuning word
//   voice_gate  : per-voice sounding flag
//   voice_note  : per-voice note index, voice v at [4v+3:4v]
//   voice_inc   : per-voice tuning word, voice v at [INC_W*v +: INC_W]
//   steal_pulse : one-cycle pulse when an active voice is reassigned
//   busy        : 1 while a mask change is being scanned
// A settled mask change is scanned one key per cycle in ascending order;
// note-on takes the lowest free voice or steals the oldest active one.
module voice_alloc
  import voice_pkg::*;
#(
  parameter int NV    = 4,
  parameter int INC_W = 24,
  parameter int AGE_W = 4
) (
  input  logic                clk,
  input  logic                ar,
  input  logic [NKEYS-1:0]    key_mask,
  input  logic [1:0]          octave,
  output logic [NV-1:0]       voice_gate,
  output logic [4*NV-1:0]     voice_note,
  output logic [INC_W*NV-1:0] voice_inc,
  output logic                steal_pulse,
  output logic                busy
);
  localparam logic [AGE_W-1:0] AGE_MAX = '1;

  logic [NKEYS-1:0] mask_s;
  logic             stable;

  mask_sync #(.W(NKEYS)) u_sync (
    .clk    (clk),
    .ar     (ar),
    .din    (key_mask),
    .dout   (mask_s),
    .stable (stable)
  );

  state_e                        state_q, state_d;
  logic [NOTE_W-1:0]             idx_q, idx_d;
  logic [NKEYS-1:0]              snap_q, snap_d, diff_q, diff_d, prev_q, prev_d;
  logic [NV-1:0]                 gate_q, gate_d;
  logic [NV-1:0][NOTE_W-1:0]     note_q, note_d;
  logic [NV-1:0][AGE_W-1:0]      age_q, age_d;
  logic [NV-1:0][INC_W-1:0]      inc_q, inc_d;
  logic                          steal_q, steal_d;

  logic             held, found;
  int               tgt;
  logic [AGE_W-1:0] best;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    snap_d  = snap_q;
    diff_d  = diff_q;
    prev_d  = prev_q;
    gate_d  = gate_q;
    note_d  = note_q;
    age_d   = age_q;
    steal_d = 1'b0;
    held    = 1'b0;
    found   = 1'b0;
    tgt     = 0;
    best    = '0;

    case (state_q)
      IDLE: begin
        if (stable && (mask_s != prev_q)) begin
          snap_d  = mask_s;
          diff_d  = mask_s ^ prev_q;
          idx_d   = '0;
          state_d = SCAN;
        end
      end
      SCAN: begin
        if (diff_q[idx_q]) begin
          if (snap_q[idx_q]) begin
            for (int v = 0; v < NV; v++)
              if (gate_q[v] && note_q[v] == idx_q) held = 1'b1;
            if (!held) begin
              for (int v = 0; v < NV; v++)
                if (!found && !gate_q[v]) begin
                  found = 1'b1;
                  tgt   = v;
                end
              if (!found) begin
                // All voices busy: strict '>' keeps the lowest index on ties.
                best = age_q[0];
                for (int v = 1; v < NV; v++)
                  if (age_q[v] > best) begin
                    best = age_q[v];
                    tgt  = v;
                  end
                steal_d = 1'b1;
              end
              for (int v = 0; v < NV; v++) begin
                if (v == tgt) begin
                  note_d[v] = idx_q;
                  gate_d[v] = 1'b1;
                  age_d[v]  = '0;
                end else if (gate_q[v] && age_q[v] != AGE_MAX) begin
                  age_d[v] = age_q[v] + 1'b1;
                end
              end
            end
          end else begin
            // Release keeps note/age so the downstream tail stays in tune.
            for (int v = 0; v < NV; v++)
              if (gate_q[v] && note_q[v] == idx_q) gate_d[v] = 1'b0;
          end
        end
        if (idx_q == NOTE_W'(NKEYS - 1)) begin
          prev_d  = snap_q;
          state_d = IDLE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    for (int v = 0; v < NV; v++)
      inc_d[v] = INC_W'(tune(note_q[v])) << octave;
  end

  always_ff @(posedge clk) begin
    if (ar) begin
      state_q <= IDLE;
      idx_q   <= '0;
      snap_q  <= '0;
      diff_q  <= '0;
      prev_q  <= '0;
      gate_q  <= '0;
      note_q  <= '0;
      age_q   <= '0;
      steal_q <= 1'b0;
      for (int v = 0; v < NV; v++) inc_q[v] <= INC_W'(TUNE[0]);
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      snap_q  <= snap_d;
      diff_q  <= diff_d;
      prev_q  <= prev_d;
      gate_q  <= gate_d;
      note_q  <= note_d;
      age_q   <= age_d;
      steal_q <= steal_d;
      inc_q   <= inc_d;
    end
  end

  assign voice_gate  = gate_q;
  assign voice_note  = note_q;
  assign voice_inc   = inc_q;
  assign steal_pulse = steal_q;
  assign busy        = (state_q == SCAN);
endmodule

// File: tb/tb_voice_alloc.sv
// Scoreboard bench for voice_alloc: stimulus pushes per-scan expectations
// from a timestamp-based allocation model; a negedge monitor checks them.
module tb_voice_alloc;
  localparam int NV    = 4;
  localparam int INC_W = 24;
  localparam int AGE_W = 4;

  logic                clk = 1'b0;
  logic                ar  = 1'b1;
  logic [11:0]         key_mask = '0;
  logic [1:0]          octave   = '0;
  logic [NV-1:0]       voice_gate;
  logic [4*NV-1:0]     voice_note;
  logic [INC_W*NV-1:0] voice_inc;
  logic                steal_pulse, busy;

  voice_alloc #(.NV(NV), .INC_W(INC_W), .AGE_W(AGE_W)) dut (
    .clk(clk), .ar(ar), .key_mask(key_mask), .octave(octave),
    .voice_gate(voice_gate), .voice_note(voice_note), .voice_inc(voice_inc),
    .steal_pulse(steal_pulse), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic                        abort;
    logic [31:0]                 start;
    logic [11:0][NV-1:0]         gtr;
    logic [11:0][NV-1:0][3:0]    ntr;
    logic [11:0]                 str;
    logic [NV-1:0][INC_W-1:0]    inc;
  } exp_t;

  exp_t q[$];

  task automatic chk(input bit ok, input string nm, input logic [127:0] act,
                     input logic [127:0] want);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, want);
    end
  endtask

  function automatic int tune_ref(input int n);
    case (n)
      0: return 22474;  1: return 23810;  2: return 25226;  3: return 26726;
      4: return 28315;  5: return 29998;  6: return 31782;  7: return 33672;
      8: return 35674;  9: return 37796; 10: return 40043; 11: return 42424;
      default: return 0;
    endcase
  endfunction

  // Reference model: age of an active voice = allocations since it was
  // allocated (timestamp difference), capped at 2^AGE_W-1.
  int          m_gate[NV];
  int          m_note[NV];
  int          m_at[NV];
  int          m_cnt;
  logic [11:0] m_prev;

  task automatic model_reset();
    for (int v = 0; v < NV; v++) begin
      m_gate[v] = 0; m_note[v] = 0; m_at[v] = 0;
    end
    m_cnt  = 0;
    m_prev = '0;
  endtask

  task automatic model_run(input logic [11:0] mask, output exp_t e);
    logic [11:0] diff;
    diff = mask ^ m_prev;
    e = '0;
    for (int k = 0; k < 12; k++) begin
      bit stl; bit held; int tgt; int best; int a;
      stl = 0; held = 0; tgt = -1; best = -1;
      if (diff[k] && mask[k]) begin
        for (int v = 0; v < NV; v++)
          if (m_gate[v] != 0 && m_note[v] == k) held = 1;
        if (!held) begin
          for (int v = 0; v < NV; v++)
            if (tgt < 0 && m_gate[v] == 0) tgt = v;
          if (tgt < 0) begin
            stl = 1;
            for (int v = 0; v < NV; v++) begin
              a = m_cnt - m_at[v];
              if (a > (1 << AGE_W) - 1) a = (1 << AGE_W) - 1;
              if (a > best) begin best = a; tgt = v; end
            end
          end
          m_cnt++;
          m_gate[tgt] = 1;
          m_note[tgt] = k;
          m_at[tgt]   = m_cnt;
        end
      end else if (diff[k]) begin
        for (int v = 0; v < NV; v++)
          if (m_gate[v] != 0 && m_note[v] == k) m_gate[v] = 0;
      end
      for (int v = 0; v < NV; v++) begin
        e.gtr[k][v] = (m_gate[v] != 0);
        e.ntr[k][v] = 4'(m_note[v]);
      end
      e.str[k] = stl;
    end
    for (int v = 0; v < NV; v++)
      e.inc[v] = INC_W'(tune_ref(m_note[v]) << octave);
    m_prev = mask;
  endtask

  // Called at a negedge; the next posedge is the first to sample the mask,
  // so the scan FSM is expected to go busy three edges after that.
  task automatic issue(input logic [11:0] m);
    exp_t e;
    if (m != m_prev) begin
      model_run(m, e);
      e.abort = 1'b0;
      e.start = 32'(cyc + 4);
      q.push_back(e);
    end
    key_mask = m;
    repeat (22) @(negedge clk);
  endtask

  // Monitor
  bit   mon_en   = 0;
  bit   in_scan  = 0;
  bit   pend_inc = 0;
  int   j        = 0;
  exp_t cur;

  always @(negedge clk) begin
    if (mon_en) begin
      if (pend_inc) begin
        chk(voice_inc == cur.inc, "inc_after_scan", 128'(voice_inc), 128'(cur.inc));
        pend_inc = 0;
      end
      if (busy === 1'b1 && !in_scan) begin
        if (q.size() == 0) begin
          chk(1'b0, "spurious_scan", 128'(cyc), 128'(0));
          cur = '0;
          cur.abort = 1'b1;
        end else begin
          cur = q.pop_front();
          chk(32'(cyc) == cur.start, "scan_start_cycle", 128'(cyc), 128'(cur.start));
        end
        in_scan = 1;
        j = 0;
      end else if (in_scan) begin
        if (cur.abort && !busy) begin
          chk({voice_gate, voice_note, steal_pulse, busy} == '0, "reset_mid_scan",
              128'({voice_gate, voice_note, steal_pulse, busy}), 128'(0));
          chk(voice_inc == {NV{24'd22474}}, "reset_inc",
              128'(voice_inc), 128'({NV{24'd22474}}));
          in_scan = 0;
        end else begin
          chk({voice_gate, voice_note, steal_pulse} == {cur.gtr[j], cur.ntr[j], cur.str[j]},
              $sformatf("scan_idx%0d_gate_note_steal", j),
              128'({voice_gate, voice_note, steal_pulse}),
              128'({cur.gtr[j], cur.ntr[j], cur.str[j]}));
          j++;
          if (j == 12) begin
            chk(busy == 1'b0, "scan_end_busy", 128'(busy), 128'(0));
            in_scan  = 0;
            pend_inc = 1;
          end
        end
      end
    end
  end

  initial begin
    exp_t e;
    model_reset();
    ar = 1'b1;
    repeat (3) @(negedge clk);
    chk({voice_gate, voice_note, steal_pulse, busy} == '0, "reset_state",
        128'({voice_gate, voice_note, steal_pulse, busy}), 128'(0));
    chk(voice_inc == {NV{24'd22474}}, "reset_inc_state",
        128'(voice_inc), 128'({NV{24'd22474}}));
    ar = 1'b0;
    mon_en = 1;
    repeat (2) @(negedge clk);

    // single key, two keys then octave retune, release
    issue(12'h001);
    issue(12'h201);
    octave = 2'd2;
    issue(12'h000);
    octave = 2'd0;

    // fill all voices one by one, then steal the oldest
    issue(12'h001);
    issue(12'h003);
    issue(12'h007);
    issue(12'h00F);
    issue(12'h01F);

    // release one of two held keys
    issue(12'h000);
    issue(12'h003);
    issue(12'h001);

    // skewed two-bit change: bit 0 drops, bit 5 rises one cycle later
    key_mask = 12'h000;
    @(negedge clk);
    key_mask = 12'h020;
    model_run(12'h020, e);
    e.abort = 1'b0;
    e.start = 32'(cyc + 4);
    q.push_back(e);
    repeat (22) @(negedge clk);

    // reset in the middle of a scan, then rediscovery from an empty state
    issue(12'h000);
    model_run(12'h00F, e);
    e.abort = 1'b1;
    e.start = 32'(cyc + 4);
    q.push_back(e);
    key_mask = 12'h00F;
    repeat (8) @(negedge clk);
    ar = 1'b1;
    @(negedge clk);
    ar = 1'b0;
    model_reset();
    model_run(12'h00F, e);
    e.abort = 1'b0;
    e.start = 32'(cyc + 4);
    q.push_back(e);
    repeat (22) @(negedge clk);

    // random mask updates with occasional octave changes
    for (int it = 0; it < 40; it++) begin
      logic [11:0] m;
      m = 12'($urandom_range(0, 4095));
      if ($urandom_range(0, 1) == 1) m = m & 12'($urandom_range(0, 4095));
      if ($urandom_range(0, 3) == 0) octave = 2'($urandom_range(0, 3));
      issue(m);
    end

    repeat (5) @(negedge clk);
    chk(q.size() == 0 && !in_scan, "scoreboard_drained", 128'(q.size()), 128'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
